// File: rtl/iob_fir_seq_pkg.sv
// Shared definitions for the time-multiplexed FIR sequencer: FSM state
// encodings and the minimum accumulator width rule.
package iob_fir_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Smallest accumulator that cannot overflow: full product width plus
  // one growth bit per doubling of the tap count.
  function automatic int min_acc_w(input int data_w, input int coef_w, input int addr_w);
    return data_w + coef_w + addr_w;
  endfunction

endpackage

// File: rtl/iob_fir_mac.sv
// Shared signed multiply-accumulate unit: one COEF_W x DATA_W product per
// enabled cycle, sign-extended and added into an ACC_W accumulator.
module iob_fir_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q;

  assign prod     = coef * sample;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign acc      = acc_q;

  // Accumulator register: clear wins over enable so a new sample starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + prod_ext;
    end
  end

endmodule

// File: rtl/iob_fir_seq.sv
// Time-multiplexed FIR sequencer: one shared MAC walks all taps of the
// circular sample delay line for each accepted sample, then holds the
// result until the consumer takes it.
module iob_fir_seq
  import iob_fir_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int N_TAPS = 8,
  parameter int ADDR_W = 3,
  parameter int ACC_W  = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_data,
  output logic                     busy
);

  // k runs one past the last tap: that extra MAC cycle lets the final
  // product settle in the accumulator before it is copied to out_data.
  localparam logic [ADDR_W:0]   K_DONE  = (ADDR_W+1)'(N_TAPS);
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(N_TAPS-1);

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]           k_q, k_d;
  logic signed [ACC_W-1:0]   out_data_q;
  logic signed [COEF_W-1:0]  coef_q  [N_TAPS];
  logic signed [DATA_W-1:0]  dline_q [N_TAPS];

  logic                      accept, mac_clear, mac_en, latch, cfg_write;
  logic [ADDR_W-1:0]         ptr_nxt, kidx, rd_idx;
  logic signed [ACC_W-1:0]   acc;

  assign in_ready  = rst & ~clr & (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;
  assign cfg_write = cfg_we & ~clr & (state_q == ST_IDLE) & ({1'b0, cfg_addr} < K_DONE);

  // Pointer arithmetic with explicit wrap so non-power-of-2 tap counts work.
  always_comb begin
    ptr_nxt = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + ADDR_W'(1);
    kidx    = (k_q < K_DONE) ? k_q[ADDR_W-1:0] : '0;
    if (kidx > wr_ptr_q) rd_idx = wr_ptr_q + (PTR_MAX - kidx) + ADDR_W'(1);
    else                 rd_idx = wr_ptr_q - kidx;
  end

  // Next-state and control decode; clr overrides every other request.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    k_d       = k_q;
    accept    = 1'b0;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    latch     = 1'b0;
    if (clr) begin
      state_d   = ST_IDLE;
      wr_ptr_d  = '0;
      k_d       = '0;
      mac_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            accept    = 1'b1;
            wr_ptr_d  = ptr_nxt;
            k_d       = '0;
            mac_clear = 1'b1;
            state_d   = ST_MAC;
          end
        end
        ST_MAC: begin
          if (k_q == K_DONE) begin
            latch   = 1'b1;
            state_d = ST_OUT;
          end else begin
            mac_en = 1'b1;
            k_d    = k_q + (ADDR_W+1)'(1);
          end
        end
        ST_OUT: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM, pointer, tap index and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      k_q        <= '0;
      out_data_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      k_q      <= k_d;
      if (latch) out_data_q <= acc;
    end
  end

  // Coefficient file: survives clr, only writable while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TAPS; i++) coef_q[i] <= '0;
    end else if (cfg_write) begin
      coef_q[cfg_addr] <= cfg_data;
    end
  end

  // Sample delay line: newest sample goes into the slot after wr_ptr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TAPS; i++) dline_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < N_TAPS; i++) dline_q[i] <= '0;
    end else if (accept) begin
      dline_q[ptr_nxt] <= in_data;
    end
  end

  iob_fir_mac #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (mac_clear),
    .en    (mac_en),
    .coef  (coef_q[kidx]),
    .sample(dline_q[rd_idx]),
    .acc   (acc)
  );

endmodule
